// File: rtl/cam_arbiter.sv
// Round-robin arbiter sharing one CAM between several requesters.
// Fixed-latency in-order pipeline (issue -> wait -> response) routes reads back to their source.
module cam_arbiter #(
    parameter int unsigned num_req_p   = 2,
    parameter int unsigned key_width_p = 16,
    parameter int unsigned val_width_p = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [num_req_p-1:0]               req_valid_i,
    output logic [num_req_p-1:0]               req_ready_o,
    input  logic [num_req_p-1:0]               req_rw_n_i,
    input  logic [num_req_p*key_width_p-1:0]   req_key_i,
    input  logic [num_req_p*val_width_p-1:0]   req_val_i,
    output logic [num_req_p-1:0]               resp_valid_o,
    output logic [val_width_p-1:0]             resp_val_o,
    output logic                               resp_hit_o,
    output logic                               cam_valid_o,
    output logic                               cam_rw_n_o,
    output logic [key_width_p-1:0]             cam_key_o,
    output logic [val_width_p-1:0]             cam_val_o,
    input  logic [val_width_p-1:0]             cam_rdata_i,
    input  logic                               cam_hit_i
);

    localparam int unsigned id_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    logic [id_w_lp-1:0]     rr_q;
    logic [num_req_p-1:0]   pending_q;
    logic [num_req_p-1:0]   elig;
    logic                   grant_found;
    logic [id_w_lp-1:0]     grant_id;
    logic [id_w_lp-1:0]     rr_next;
    logic                   accept;
    int unsigned            scan;

    logic                   sel_rw;
    logic [key_width_p-1:0] sel_key;
    logic [val_width_p-1:0] sel_val;
    logic [num_req_p-1:0]   set_mask;
    logic [num_req_p-1:0]   clr_mask;

    logic [id_w_lp-1:0]     iss_id_q;
    logic                   wait_rd_q;
    logic [id_w_lp-1:0]     wait_id_q;

    assign elig = req_valid_i & ~pending_q;

    // First eligible requester scanning upward from rr_q, wrapping modulo num_req_p.
    always_comb begin : grant_scan
        grant_found = 1'b0;
        grant_id    = '0;
        scan        = 0;
        for (int unsigned k = 0; k < num_req_p; k++) begin
            scan = 32'(rr_q) + k;
            if (scan >= num_req_p) begin
                scan = scan - num_req_p;
            end
            if (!grant_found && elig[id_w_lp'(scan)]) begin
                grant_found = 1'b1;
                grant_id    = id_w_lp'(scan);
            end
        end
    end

    assign accept  = grant_found && !rst;
    assign rr_next = (32'(grant_id) == num_req_p - 1) ? '0 : grant_id + id_w_lp'(1);

    always_comb begin : ready_gen
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    always_comb begin : req_mux
        sel_rw  = 1'b0;
        sel_key = '0;
        sel_val = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            if (grant_id == id_w_lp'(i)) begin
                sel_rw  = req_rw_n_i[i];
                sel_key = req_key_i[i*key_width_p +: key_width_p];
                sel_val = req_val_i[i*val_width_p +: val_width_p];
            end
        end
    end

    // Reads mark their requester busy at accept; the response edge releases it.
    always_comb begin : pending_masks
        set_mask = '0;
        clr_mask = '0;
        if (accept && sel_rw) begin
            set_mask[grant_id] = 1'b1;
        end
        if (wait_rd_q) begin
            clr_mask[wait_id_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q         <= '0;
            pending_q    <= '0;
            cam_valid_o  <= 1'b0;
            cam_rw_n_o   <= 1'b0;
            cam_key_o    <= '0;
            cam_val_o    <= '0;
            iss_id_q     <= '0;
            wait_rd_q    <= 1'b0;
            wait_id_q    <= '0;
            resp_valid_o <= '0;
            resp_val_o   <= '0;
            resp_hit_o   <= 1'b0;
        end else begin
            cam_valid_o <= accept;
            if (accept) begin
                cam_rw_n_o <= sel_rw;
                cam_key_o  <= sel_key;
                cam_val_o  <= sel_val;
                iss_id_q   <= grant_id;
                rr_q       <= rr_next;
            end

            wait_rd_q <= cam_valid_o && cam_rw_n_o;
            wait_id_q <= iss_id_q;

            // CAM data for the wait-stage read is present this cycle; register it out.
            resp_valid_o <= '0;
            if (wait_rd_q) begin
                resp_valid_o[wait_id_q] <= 1'b1;
                resp_val_o              <= cam_rdata_i;
                resp_hit_o              <= cam_hit_i;
            end

            pending_q <= (pending_q | set_mask) & ~clr_mask;
        end
    end

    a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready_o));
    a_resp_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(resp_valid_o));
    a_no_overlap:   assert property (@(posedge clk) disable iff (rst) (set_mask & clr_mask) == '0);

endmodule

// File: tb/tb_cam_arbiter.sv
// Directed bench for cam_arbiter with a behavioural FIFO-eviction CAM and
// scoreboard queues for CAM accesses and read responses.
module tb_cam_arbiter;

    localparam int unsigned NREQ    = 2;
    localparam int unsigned KW      = 16;
    localparam int unsigned VW      = 16;
    localparam int unsigned CAMSIZE = 4;
    localparam int          MAXWAIT = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid_i = '0;
    logic [NREQ-1:0]   req_ready_o;
    logic [NREQ-1:0]   req_rw_n_i = '0;
    logic [NREQ*KW-1:0] req_key_i = '0;
    logic [NREQ*VW-1:0] req_val_i = '0;
    logic [NREQ-1:0]   resp_valid_o;
    logic [VW-1:0]     resp_val_o;
    logic              resp_hit_o;
    logic              cam_valid_o;
    logic              cam_rw_n_o;
    logic [KW-1:0]     cam_key_o;
    logic [VW-1:0]     cam_val_o;
    logic [VW-1:0]     cam_rdata_i = '0;
    logic              cam_hit_i = 1'b0;

    always #5 clk = ~clk;

    cam_arbiter #(
        .num_req_p   (NREQ),
        .key_width_p (KW),
        .val_width_p (VW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_rw_n_i   (req_rw_n_i),
        .req_key_i    (req_key_i),
        .req_val_i    (req_val_i),
        .resp_valid_o (resp_valid_o),
        .resp_val_o   (resp_val_o),
        .resp_hit_o   (resp_hit_o),
        .cam_valid_o  (cam_valid_o),
        .cam_rw_n_o   (cam_rw_n_o),
        .cam_key_o    (cam_key_o),
        .cam_val_o    (cam_val_o),
        .cam_rdata_i  (cam_rdata_i),
        .cam_hit_i    (cam_hit_i)
    );

    typedef struct packed {
        logic          rw_n;
        logic [KW-1:0] key;
        logic [VW-1:0] val;
    } cam_t;

    typedef struct packed {
        logic [NREQ-1:0] who;
        logic [VW-1:0]   val;
        logic            hit;
    } resp_t;

    cam_t  cam_q[$];
    resp_t resp_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    logic [VW-1:0] fill_exp_val [5] = '{16'h0000, 16'h5001, 16'h5002, 16'h5003, 16'h5004};
    logic          fill_exp_hit [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural CAM: FIFO replacement, read data one cycle after the strobe.
    logic [KW-1:0] mk    [CAMSIZE];
    logic [VW-1:0] mv    [CAMSIZE];
    logic          mused [CAMSIZE];
    int            mwp = 0;
    logic          flush = 1'b1;

    function automatic int lookup(input logic [KW-1:0] key);
        lookup = -1;
        for (int i = 0; i < int'(CAMSIZE); i++) begin
            if (mused[i] && mk[i] == key) lookup = i;
        end
    endfunction

    always @(posedge clk) begin
        int idx;
        if (flush) begin
            for (int i = 0; i < int'(CAMSIZE); i++) mused[i] = 1'b0;
            mwp = 0;
        end else if (cam_valid_o === 1'b1) begin
            idx = lookup(cam_key_o);
            if (!cam_rw_n_o) begin
                if (idx >= 0) begin
                    mv[idx] = cam_val_o;
                end else begin
                    mk[mwp]    = cam_key_o;
                    mv[mwp]    = cam_val_o;
                    mused[mwp] = 1'b1;
                    mwp        = (mwp + 1) % int'(CAMSIZE);
                end
            end else begin
                cam_hit_i   <= (idx >= 0);
                cam_rdata_i <= (idx >= 0) ? mv[idx] : '0;
            end
        end
    end

    always @(negedge clk) begin
        cam_t  ce;
        resp_t re;
        if (cam_valid_o === 1'b1) begin
            if (cam_q.size() == 0) begin
                check("cam unexpected", 64'(cam_valid_o), '0);
            end else begin
                ce = cam_q.pop_front();
                check("cam access", 64'({cam_rw_n_o, cam_key_o, cam_val_o}), 64'(ce));
            end
        end
        if (|resp_valid_o) begin
            if (resp_q.size() == 0) begin
                check("resp unexpected", 64'(resp_valid_o), '0);
            end else begin
                re = resp_q.pop_front();
                check("resp", 64'({resp_valid_o, resp_val_o, resp_hit_o}), 64'(re));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic v, input logic rw_n,
                         input logic [KW-1:0] key, input logic [VW-1:0] val);
        req_valid_i[id]          = v;
        req_rw_n_i[id]           = rw_n;
        req_key_i[id*KW +: KW]   = key;
        req_val_i[id*VW +: VW]   = val;
    endtask

    function automatic logic [NREQ-1:0] oh(input int id);
        oh     = '0;
        oh[id] = 1'b1;
    endfunction

    task automatic do_req(input int id, input logic rw_n, input logic [KW-1:0] key,
                          input logic [VW-1:0] val, input logic [VW-1:0] exp_val,
                          input logic exp_hit);
        int n = 0;
        drive(id, 1'b1, rw_n, key, val);
        @(negedge clk);
        while (!req_ready_o[id] && n < MAXWAIT) begin
            cyc();
            @(negedge clk);
            n++;
        end
        check("grant within budget", 64'(req_ready_o[id]), 64'(1'b1));
        if (req_ready_o[id]) begin
            cam_q.push_back(cam_t'({rw_n, key, val}));
            if (rw_n) resp_q.push_back(resp_t'({oh(id), exp_val, exp_hit}));
        end
        cyc();
        req_valid_i[id] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [KW-1:0] k0, k1;
        logic [VW-1:0] v0, v1;

        // Reset held with both requesters asking.
        req_valid_i = '1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset ready", 64'(req_ready_o), '0);
            check("reset cam_valid", 64'(cam_valid_o), '0);
            check("reset resp_valid", 64'(resp_valid_o), '0);
        end
        check("reset outputs", 64'({resp_val_o, resp_hit_o, cam_rw_n_o, cam_key_o, cam_val_o}), '0);

        // Both requesters write continuously; grants alternate from requester 0.
        k0 = 16'h0001; v0 = 16'h1001;
        k1 = 16'h0100; v1 = 16'h2100;
        drive(0, 1'b1, 1'b0, k0, v0);
        drive(1, 1'b1, 1'b0, k1, v1);
        cyc();
        rst   = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("alternating grant", 64'(req_ready_o), 64'(oh(i % 2)));
            if (i > 0) check("cam busy", 64'(cam_valid_o), 64'(1'b1));
            if (i % 2 == 0) cam_q.push_back(cam_t'({1'b0, k0, v0}));
            else            cam_q.push_back(cam_t'({1'b0, k1, v1}));
            cyc();
            if (i % 2 == 0) begin
                k0 = k0 + 16'(1); v0 = v0 + 16'(1);
                drive(0, 1'b1, 1'b0, k0, v0);
            end else begin
                k1 = k1 + 16'(1); v1 = v1 + 16'(1);
                drive(1, 1'b1, 1'b0, k1, v1);
            end
        end
        req_valid_i = '0;

        // Write then immediate read of the same key from requester 0.
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(0, 1'b1, 1'b0, 16'h00AA, 16'h1234);
        @(negedge clk);
        check("write grant", 64'(req_ready_o), 64'(2'b01));
        cam_q.push_back(cam_t'({1'b0, 16'h00AA, 16'h1234}));
        cyc();
        drive(0, 1'b1, 1'b1, 16'h00AA, 16'h1234);
        @(negedge clk);
        check("read after write grant", 64'(req_ready_o), 64'(2'b01));
        cam_q.push_back(cam_t'({1'b1, 16'h00AA, 16'h1234}));
        resp_q.push_back(resp_t'({2'b01, 16'h1234, 1'b1}));
        cyc();
        req_valid_i = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wr-rd response timing", 64'(resp_valid_o), 64'((i == 2) ? 2'b01 : 2'b00));
        end
        cyc();

        // Requester 1 misses; it is blocked until its response while requester 0 streams.
        drive(1, 1'b1, 1'b1, 16'hBEEF, 16'h0000);
        @(negedge clk);
        check("miss read grant", 64'(req_ready_o), 64'(2'b10));
        cam_q.push_back(cam_t'({1'b1, 16'hBEEF, 16'h0000}));
        resp_q.push_back(resp_t'({2'b10, 16'h0000, 1'b0}));
        cyc();
        drive(1, 1'b1, 1'b0, 16'h0B00, 16'h0B0B);
        drive(0, 1'b1, 1'b0, 16'h0A00, 16'h0A0A);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("pending blocks r1", 64'(req_ready_o), 64'((i == 2) ? 2'b10 : 2'b01));
            check("miss response timing", 64'(resp_valid_o), 64'((i == 2) ? 2'b10 : 2'b00));
            if (i < 2) cam_q.push_back(cam_t'({1'b0, 16'h0A00 + 16'(i), 16'h0A0A + 16'(i)}));
            else       cam_q.push_back(cam_t'({1'b0, 16'h0B00, 16'h0B0B}));
            cyc();
            if (i < 2) drive(0, 1'b1, 1'b0, 16'h0A01 + 16'(i), 16'h0A0B + 16'(i));
            else       req_valid_i[1] = 1'b0;
        end
        @(negedge clk);
        check("r0 resumes", 64'(req_ready_o), 64'(2'b01));
        cam_q.push_back(cam_t'({1'b0, 16'h0A02, 16'h0A0C}));
        cyc();
        req_valid_i = '0;

        // Fill CAMSIZE+1 keys, then read all back; the first key was evicted.
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        for (int i = 0; i < 5; i++)
            do_req(i % 2, 1'b0, 16'h0C00 + 16'(i), 16'h5000 + 16'(i), 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++)
            do_req(i % 2, 1'b1, 16'h0C00 + 16'(i), 16'h0000, fill_exp_val[i], fill_exp_hit[i]);
        repeat (5) cyc();

        // Reset one cycle after a read is accepted discards it.
        drive(0, 1'b1, 1'b1, 16'h0C01, 16'h0000);
        @(negedge clk);
        check("pre-reset grant", 64'(req_ready_o), 64'(2'b01));
        cam_q.push_back(cam_t'({1'b1, 16'h0C01, 16'h0000}));
        cyc();
        rst = 1'b1;
        drive(0, 1'b1, 1'b1, 16'h0C02, 16'h0000);
        @(negedge clk);
        check("ready during reset", 64'(req_ready_o), '0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("eligible after reset", 64'(req_ready_o), 64'(2'b01));
        cam_q.push_back(cam_t'({1'b1, 16'h0C02, 16'h0000}));
        resp_q.push_back(resp_t'({2'b01, 16'h5002, 1'b1}));
        cyc();
        req_valid_i = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post-reset response", 64'(resp_valid_o), 64'((i == 2) ? 2'b01 : 2'b00));
        end

        repeat (6) cyc();
        check("resp queue drained", 64'(resp_q.size()), '0);
        check("cam queue drained", 64'(cam_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cam_arbiter.md
Name: cam_arbiter

Overview:
- Shares one CAM instance (camsize_p entries, key/value store with hit/evict behaviour) between num_req_p independent requesters.
- Round-robin arbitration; at most one CAM access issued per cycle.
- Read results are routed back to the originating requester.
- Sits between the requester blocks and the CAM. It is the sole driver of the CAM request port.

Parameters:
- num_req_p, 2, number of requesters (2..4).
- key_width_p, 16, CAM key width.
- val_width_p, 16, CAM value width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid_i  in  num_req_p  request valid per requester.
- req_ready_o  out  num_req_p  request accepted when valid&ready at posedge.
- req_rw_n_i  in  num_req_p  per requester: 1 = read, 0 = write.
- req_key_i  in  num_req_p*key_width_p  packed keys; requester i at [i*key_width_p +: key_width_p].
- req_val_i  in  num_req_p*val_width_p  packed write values, same packing.
- resp_valid_o  out  num_req_p  one-cycle read-response pulse per requester.
- resp_val_o  out  val_width_p  read data, shared bus; meaningful only with a resp_valid_o bit set.
- resp_hit_o  out  1  key was present; valid with resp_valid_o.
- cam_valid_o  out  1  CAM access strobe.
- cam_rw_n_o  out  1  1 = read, 0 = write.
- cam_key_o  out  key_width_p  CAM key.
- cam_val_o  out  val_width_p  CAM write value.
- cam_rdata_i  in  val_width_p  CAM read data; valid the cycle after a read strobe.
- cam_hit_i  in  1  CAM hit flag; same timing as cam_rdata_i.

Behaviour:
- Reset:
  - All outputs are 0: req_ready_o, resp_valid_o, resp_val_o, resp_hit_o and all cam_* outputs.
  - Round-robin pointer rr_q = 0; all pending_q bits = 0; pipeline stage valids = 0.
- Eligibility and ready:
  - Requester i is eligible when req_valid_i[i] && !pending_q[i].
  - req_ready_o is combinational and one-hot-or-zero: only the granted requester sees ready. The rst term forces it to 0 during reset.
- Grant:
  - The first eligible index starting at rr_q and scanning upward mod num_req_p.
  - On any grant g, rr_q <= (g+1) mod num_req_p. With no grant, rr_q holds.
- Issue stage (cycle t = acceptance edge):
  - Registered. In cycle t+1: cam_valid_o=1, with cam_rw_n_o/cam_key_o/cam_val_o equal to the accepted request.
  - In cycles with no accept on the previous edge, cam_valid_o=0 and the other cam_* outputs hold their last values.
  - The issue stage also carries the requester id.
- Writes:
  - Fire-and-forget. No response and no pending bit.
  - The requester may be granted again on the next cycle.
- Reads:
  - On accept, pending_q[g] is set. A wait stage records the id and read flag in cycle t+1.
  - In cycle t+2 the CAM presents cam_rdata_i/cam_hit_i. These are registered.
  - In cycle t+3: resp_valid_o[id]=1 for exactly one cycle, with resp_val_o/resp_hit_o set.
  - pending_q[id] is cleared on the edge that raises resp_valid_o, so the requester is eligible again from cycle t+3.
- Throughput:
  - One access per cycle total.
  - Each requester has at most one outstanding read.
  - Back-to-back writes from one requester are allowed.
- Ordering: accesses reach the CAM in grant order. A write granted at t followed by a read of the same key granted at t+1 produces consecutive CAM cycles; the read sees the written value (the CAM guarantees write-then-read consistency).
- No reordering of responses: the pipeline is in-order and fixed latency. resp_val_o is a single bus because at most one response is produced per cycle.
- Simultaneous: a response for requester i and a new acceptance from requester i cannot collide, since i is ineligible until its pending bit clears.
- Mid-operation reset: in-flight issue/wait/response stages are discarded. No resp_valid_o is produced for them, and pending_q clears.
- A requester dropping req_valid_i without a handshake is legal. Nothing is issued.

Test Plan:
- Reset hold 3 cycles with both req_valid_i=1 -> req_ready_o=0, cam_valid_o=0, resp_valid_o=0 throughout. After the rst fall, requester 0 is granted first (rr_q=0).
- Both requesters write continuously (r0 key 0x0001..., r1 key 0x0100...) -> grants alternate 0,1,0,1; cam_valid_o high every cycle from the second cycle on; keys appear at the CAM one cycle after acceptance.
- r0 writes key 0x00AA val 0x1234 at t, then reads 0x00AA at t+1 -> CAM sees write at t+1 and read at t+2; resp_valid_o=2'b01 at t+4 with resp_val_o=0x1234, resp_hit_o=1.
- r1 reads absent key 0xBEEF (cam_hit_i=0) -> resp_valid_o=2'b10 exactly 3 cycles after acceptance, resp_hit_o=0. req_ready_o[1] stays 0 until that cycle even with req_valid_i[1]=1, while r0 continues to be granted.
- Fill camsize_p+1 distinct keys from alternating requesters, then read all -> responses route to the issuing requester in grant order. Hit flags match the evicted entry, which misses.
- r0 read accepted, rst asserted one cycle later for 1 cycle -> no resp_valid_o ever appears for that read; after reset r0 is immediately eligible.
